// File: rtl/obi_resp_pkg.sv
// Shared types and helpers for the OBI memory responder.
package obi_resp_pkg;

    localparam int unsigned DATA_W = 32;
    localparam int unsigned BE_W   = DATA_W / 8;

    typedef struct packed {
        logic              valid;
        logic [DATA_W-1:0] rdata;
        logic              err;
    } obi_resp_t;

    // Replace the bytes of old selected by be with the matching bytes of wdata
    function automatic logic [DATA_W-1:0] be_merge(
        input logic [DATA_W-1:0] old,
        input logic [DATA_W-1:0] wdata,
        input logic [BE_W-1:0]   be
    );
        logic [DATA_W-1:0] res;
        res = old;
        for (int b = 0; b < BE_W; b++) begin
            if (be[b]) res[8*b +: 8] = wdata[8*b +: 8];
        end
        return res;
    endfunction

endpackage

// File: rtl/obi_resp_delay_line.sv
// Fixed-latency response pipe; reset drops in-flight responses by clearing valid only.
module obi_resp_delay_line
    import obi_resp_pkg::*;
#(
    parameter int unsigned LATENCY = 1
) (
    input  logic      clk_i,
    input  logic      rst_ni,
    input  obi_resp_t resp_i,
    output obi_resp_t resp_o
);

    obi_resp_t stage_q [LATENCY];

    always_ff @(posedge clk_i) begin
        stage_q[0] <= resp_i;
        for (int unsigned i = 1; i < LATENCY; i++) begin
            stage_q[i] <= stage_q[i-1];
        end
        if (!rst_ni) begin
            for (int unsigned i = 0; i < LATENCY; i++) begin
                stage_q[i].valid <= 1'b0;
            end
        end
    end

    assign resp_o = stage_q[LATENCY-1];

endmodule

// File: rtl/obi_mem_responder.sv
// OBI memory-side responder: word RAM with byte-enable writes, fixed-latency
// in-order responses, outstanding limit and optional periodic grant stalls.
module obi_mem_responder
    import obi_resp_pkg::*;
#(
    parameter int unsigned DEPTH           = 1024,
    parameter logic [31:0] BASE_ADDR       = 32'h0010_0000,
    parameter int unsigned LATENCY         = 1,
    parameter int unsigned MAX_OUTSTANDING = 2,
    parameter int unsigned STALL_EVERY     = 0
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              req_i,
    output logic              gnt_o,
    input  logic [31:0]       addr_i,
    input  logic              we_i,
    input  logic [BE_W-1:0]   be_i,
    input  logic [DATA_W-1:0] wdata_i,
    output logic              rvalid_o,
    output logic [DATA_W-1:0] rdata_o,
    output logic              err_o
);

    localparam int unsigned IDX_W   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned OUT_W   = $clog2(MAX_OUTSTANDING + 1);
    localparam int unsigned STALL_W = (STALL_EVERY > 1) ? $clog2(STALL_EVERY) : 1;

    logic              ready_q;
    logic              stall_q;
    logic [OUT_W-1:0]  outst_q;
    logic [STALL_W-1:0] stall_cnt_q;

    logic [DATA_W-1:0] mem [DEPTH];

    logic [31:0]       off;
    logic              in_range;
    logic [IDX_W-1:0]  idx;
    logic              accept;
    obi_resp_t         resp_in;
    obi_resp_t         resp_out;

    // rst_ni term keeps the grant low in the reset cycle itself
    assign gnt_o    = rst_ni && ready_q && (outst_q < OUT_W'(MAX_OUTSTANDING)) && !stall_q;
    assign accept   = req_i && gnt_o;
    assign off      = addr_i - BASE_ADDR;
    assign in_range = off < 32'(DEPTH * 4);
    assign idx      = off[IDX_W+1:2];

    always_ff @(posedge clk_i) begin
        if (accept && we_i && in_range) begin
            mem[idx] <= be_merge(mem[idx], wdata_i, be_i);
        end
    end

    // Response formed at the grant edge; reads see every earlier committed write
    always_comb begin
        resp_in       = '0;
        resp_in.valid = accept;
        resp_in.err   = accept && !in_range;
        if (accept && in_range && !we_i) begin
            resp_in.rdata = mem[idx];
        end
    end

    obi_resp_delay_line #(
        .LATENCY (LATENCY)
    ) u_delay (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .resp_i (resp_in),
        .resp_o (resp_out)
    );

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            ready_q     <= 1'b0;
            stall_q     <= 1'b0;
            outst_q     <= '0;
            stall_cnt_q <= '0;
        end else begin
            ready_q <= 1'b1;
            if (accept && !resp_out.valid) begin
                outst_q <= outst_q + OUT_W'(1);
            end else if (!accept && resp_out.valid) begin
                outst_q <= outst_q - OUT_W'(1);
            end
            stall_q <= 1'b0;
            if (STALL_EVERY != 0 && accept) begin
                if (stall_cnt_q == STALL_W'(STALL_EVERY - 1)) begin
                    stall_cnt_q <= '0;
                    stall_q     <= 1'b1;
                end else begin
                    stall_cnt_q <= stall_cnt_q + STALL_W'(1);
                end
            end
        end
    end

    // Stale data left in the pipe after a reset is hidden behind valid
    assign rvalid_o = resp_out.valid;
    assign rdata_o  = resp_out.valid ? resp_out.rdata : '0;
    assign err_o    = resp_out.valid && resp_out.err;

endmodule

// File: tb/tb_obi_mem_responder.sv
// Scoreboard bench for obi_mem_responder across four parameter sets sharing one bus.
module tb_obi_mem_responder;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [3:0]  req;
    logic [3:0]  gnt;
    logic [3:0]  rv;
    logic [3:0]  err;
    logic [31:0] rdata [4];
    logic [31:0] addr;
    logic        we;
    logic [3:0]  be;
    logic [31:0] wdata;

    always #5 clk = ~clk;

    obi_mem_responder #(.LATENCY(1), .MAX_OUTSTANDING(2), .STALL_EVERY(0)) u_dflt (
        .clk_i(clk), .rst_ni(rst_n), .req_i(req[0]), .gnt_o(gnt[0]), .addr_i(addr),
        .we_i(we), .be_i(be), .wdata_i(wdata), .rvalid_o(rv[0]), .rdata_o(rdata[0]), .err_o(err[0]));
    obi_mem_responder #(.LATENCY(4), .MAX_OUTSTANDING(2), .STALL_EVERY(0)) u_bp (
        .clk_i(clk), .rst_ni(rst_n), .req_i(req[1]), .gnt_o(gnt[1]), .addr_i(addr),
        .we_i(we), .be_i(be), .wdata_i(wdata), .rvalid_o(rv[1]), .rdata_o(rdata[1]), .err_o(err[1]));
    obi_mem_responder #(.LATENCY(1), .MAX_OUTSTANDING(2), .STALL_EVERY(3)) u_stall (
        .clk_i(clk), .rst_ni(rst_n), .req_i(req[2]), .gnt_o(gnt[2]), .addr_i(addr),
        .we_i(we), .be_i(be), .wdata_i(wdata), .rvalid_o(rv[2]), .rdata_o(rdata[2]), .err_o(err[2]));
    obi_mem_responder #(.LATENCY(3), .MAX_OUTSTANDING(4), .STALL_EVERY(0)) u_rst (
        .clk_i(clk), .rst_ni(rst_n), .req_i(req[3]), .gnt_o(gnt[3]), .addr_i(addr),
        .we_i(we), .be_i(be), .wdata_i(wdata), .rvalid_o(rv[3]), .rdata_o(rdata[3]), .err_o(err[3]));

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        int          cyc;
    } exp_t;

    exp_t sb [$];
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    int   sel = 0;
    int   last_wait = 0;
    int   lat_tab [4] = '{1, 4, 1, 3};
    bit   bp_mode = 1'b0;
    int   model_outst = 0;
    int   rv_cnt [4] = '{0, 0, 0, 0};

    function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endfunction

    // Cycle count and reset flush of expectations (in-flight responses are discarded)
    always @(posedge clk) begin
        cyc++;
        if (!rst_n) begin
            sb.delete();
            model_outst = 0;
        end
    end

    // Monitor: pops the scoreboard on every response of the selected instance
    always @(negedge clk) begin
        exp_t e;
        for (int i = 0; i < 4; i++) begin
            if (rv[i]) rv_cnt[i]++;
            if (i != sel && rv[i]) begin
                errors++;
                $display("FAIL stray_rvalid: instance %0d got rvalid 1 expected 0", i);
            end
        end
        if (rv[sel]) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_rvalid: got rvalid with rdata %h, expected none", rdata[sel]);
            end else begin
                e = sb.pop_front();
                chk("rdata", rdata[sel], e.rdata);
                chk("err", 32'(err[sel]), 32'(e.err));
                chk("latency", 32'(cyc - e.cyc), 32'(lat_tab[sel]));
            end
        end else if (rst_n) begin
            chk("idle_rdata_err", {rdata[sel][31:1], rdata[sel][0] | err[sel]}, 32'h0);
        end
        if (bp_mode) begin
            chk("outst_limit", 32'(model_outst > 2), 32'h0);
            if (model_outst == 2) chk("gnt_at_max_outst", 32'(gnt[sel]), 32'h0);
            else                  chk("gnt_below_max_outst", 32'(gnt[sel]), 32'h1);
            model_outst += int'(req[sel] && gnt[sel]) - int'(rv[sel]);
        end
    end

    task automatic xfer(input logic [31:0] a, input logic w, input logic [3:0] b,
                        input logic [31:0] d, input logic [31:0] exp_rd, input logic exp_err);
        int   n;
        exp_t e;
        n = 0;
        req[sel] = 1'b1;
        addr = a; we = w; be = b; wdata = d;
        @(negedge clk);
        while (!gnt[sel] && n < 100) begin
            @(negedge clk);
            n++;
        end
        last_wait = n;
        if (!gnt[sel]) begin
            checks++;
            errors++;
            $display("FAIL grant_timeout: addr %h got no gnt, expected gnt", a);
        end else begin
            e.rdata = exp_rd;
            e.err   = exp_err;
            e.cyc   = cyc;
            sb.push_back(e);
        end
        @(posedge clk);
        #1;
        req[sel] = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (sb.size() != 0 && n < 50) begin
            @(posedge clk);
            n++;
        end
        chk("drain_pending", 32'(sb.size()), 32'h0);
        @(posedge clk);
        #1;
    endtask

    initial begin
        int base;
        req = '0; addr = '0; we = 1'b0; be = '0; wdata = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset_gnt", 32'(gnt), 32'h0);
        chk("reset_rvalid", 32'(rv), 32'h0);
        chk("reset_rdata", rdata[0], 32'h0);
        chk("reset_err", 32'(err), 32'h0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        chk("first_cycle_gnt", 32'(gnt), 32'h0);
        @(posedge clk);
        #1;

        // Default instance: write/read back, byte enables, range boundaries
        sel = 0;
        xfer(32'h0010_0010, 1'b1, 4'hF, 32'hDEAD_BEEF, 32'h0, 1'b0);
        xfer(32'h0010_0010, 1'b0, 4'hF, 32'h0, 32'hDEAD_BEEF, 1'b0);
        chk("back_to_back_wait", 32'(last_wait), 32'h0);
        xfer(32'h0010_0010, 1'b1, 4'b0101, 32'h1122_3344, 32'h0, 1'b0);
        xfer(32'h0010_0010, 1'b0, 4'h0, 32'h0, 32'hDE22_BE44, 1'b0);
        xfer(32'h0010_0000, 1'b1, 4'hF, 32'hA5A5_A5A5, 32'h0, 1'b0);
        xfer(32'h0010_1000, 1'b0, 4'hF, 32'h0, 32'h0, 1'b1);
        xfer(32'h000F_FFFC, 1'b0, 4'hF, 32'h0, 32'h0, 1'b1);
        xfer(32'h0010_1000, 1'b1, 4'hF, 32'hCAFE_F00D, 32'h0, 1'b1);
        xfer(32'h0010_0FFC, 1'b1, 4'hF, 32'h1234_5678, 32'h0, 1'b0);
        xfer(32'h0010_0FFC, 1'b0, 4'hF, 32'h0, 32'h1234_5678, 1'b0);
        xfer(32'h0010_0000, 1'b0, 4'hF, 32'h0, 32'hA5A5_A5A5, 1'b0);
        xfer(32'h0010_0012, 1'b0, 4'hF, 32'h0, 32'hDE22_BE44, 1'b0);
        drain();

        // LATENCY=4, MAX_OUTSTANDING=2: grant must drop whenever two are in flight
        sel = 1;
        bp_mode = 1'b1;
        for (int i = 0; i < 8; i++)
            xfer(32'h0010_0000 + 32'(4*i), 1'b1, 4'hF, 32'h0000_1000 + 32'(i), 32'h0, 1'b0);
        for (int i = 0; i < 8; i++)
            xfer(32'h0010_0000 + 32'(4*i), 1'b0, 4'hF, 32'h0, 32'h0000_1000 + 32'(i), 1'b0);
        drain();
        bp_mode = 1'b0;

        // STALL_EVERY=3: one-cycle gnt gap after grants 3, 6, 9
        sel = 2;
        for (int k = 0; k < 12; k++) begin
            if (k < 6) xfer(32'h0010_0040 + 32'(4*k), 1'b1, 4'hF, 32'hB000_0000 + 32'(k), 32'h0, 1'b0);
            else       xfer(32'h0010_0040 + 32'(4*(k-6)), 1'b0, 4'hF, 32'h0, 32'hB000_0000 + 32'(k-6), 1'b0);
            chk($sformatf("stall_wait_%0d", k), 32'(last_wait), (k % 3 == 0 && k > 0) ? 32'h1 : 32'h0);
        end
        drain();

        // Reset with three reads in flight
        sel = 3;
        xfer(32'h0010_0020, 1'b1, 4'hF, 32'h5A5A_1234, 32'h0, 1'b0);
        drain();
        for (int i = 0; i < 3; i++)
            xfer(32'h0010_0020, 1'b0, 4'hF, 32'h0, 32'h5A5A_1234, 1'b0);
        rst_n = 1'b0;
        @(negedge clk);
        chk("gnt_in_reset", 32'(gnt[3]), 32'h0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        base = rv_cnt[3];
        @(negedge clk);
        chk("gnt_after_reset", 32'(gnt[3]), 32'h0);
        @(negedge clk);
        chk("gnt_ready_again", 32'(gnt[3]), 32'h1);
        repeat (8) @(negedge clk);
        chk("rvalid_after_reset", 32'(rv_cnt[3] - base), 32'h0);
        @(posedge clk);
        #1;
        xfer(32'h0010_0020, 1'b0, 4'hF, 32'h0, 32'h5A5A_1234, 1'b0);
        drain();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

endmodule
